// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the PC, runs a request/response handshake with instruction memory
// and hands {valid, pc, instr, pred_taken} to decode through an output
// register backed by a 1-entry skid buffer. EX redirects squash everything
// fetched but not yet consumed, including a fetch still in flight.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   imem_read/_address  fetch request and word-aligned address
//   imem_resp/_rdata    memory response and instruction word
//   id_stall            decode cannot accept this cycle
//   redirect_valid/_pc  single-cycle PC redirect from EX
//   if_valid/_pc/_instr instruction presented to decode
//   if_pred_taken       instruction was predicted as a taken JAL
//
// Optional feature macro: FETCH_JAL_PREDICT_EN (fetch follows JAL targets).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_pred_taken
);

  typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } fetch_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  fetch_t      skid_q, skid_d;
  fetch_t      out_q, out_d;
  logic        out_vld_q, out_vld_d;

  logic        out_accept;
  logic        out_load;
  logic        is_jal;
  logic [31:0] next_pc;
  fetch_t      fetched;

`ifdef FETCH_JAL_PREDICT_EN
  logic [31:0] jimm;
  logic [31:0] jtgt;
  assign is_jal  = (imem_rdata[6:0] == 7'b1101111);
  assign jimm    = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                    imem_rdata[30:21], 1'b0};
  assign jtgt    = pc_q + jimm;
  // Keep the fetch address word-aligned even for a half-word JAL offset.
  assign next_pc = is_jal ? {jtgt[31:2], 2'b00} : pc_q + 32'd4;
`else
  assign is_jal  = 1'b0;
  assign next_pc = pc_q + 32'd4;
`endif

  assign fetched    = '{pc: pc_q, instr: imem_rdata, pred: is_jal};
  assign out_accept = !out_vld_q || !id_stall;

  // Gated by rst_n so no request leaves the stage while in reset.
  assign imem_read    = rst_n && (state_q != HOLD);
  assign imem_address = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign if_valid      = out_vld_q;
  assign if_pc         = out_q.pc;
  assign if_instr      = out_q.instr;
  assign if_pred_taken = out_q.pred;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_d       = skid_q;
    out_d        = out_q;
    out_vld_d    = out_vld_q;
    out_load     = 1'b0;

    if (redirect_valid) begin
      out_vld_d = 1'b0;
      out_d     = '{pc: out_q.pc, instr: NOP_INSTR, pred: 1'b0};
      skid_d    = '0;
      pc_d      = {redirect_pc[31:2], 2'b00};
      case (state_q)
        REQ: begin
          // An unanswered request must still be retired before the new one.
          if (!imem_resp) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end
        HOLD:    state_d = REQ;
        DRAIN:   if (imem_resp) state_d = REQ;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (imem_resp) begin
            pc_d = next_pc;
            if (out_accept) begin
              out_d     = fetched;
              out_vld_d = 1'b1;
              out_load  = 1'b1;
            end else begin
              skid_d  = fetched;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!id_stall) begin
            out_d     = skid_q;
            out_vld_d = 1'b1;
            out_load  = 1'b1;
            skid_d    = '0;
            state_d   = REQ;
          end
        end
        DRAIN:   if (imem_resp) state_d = REQ;
        default: state_d = REQ;
      endcase

      // Decode took the current word and nothing replaces it.
      if (out_accept && !out_load) begin
        out_vld_d   = 1'b0;
        out_d.instr = NOP_INSTR;
        out_d.pred  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      skid_q       <= '0;
      out_q        <= '{pc: 32'd0, instr: NOP_INSTR, pred: 1'b0};
      out_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_q       <= skid_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_pred_taken;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_pred_taken(if_pred_taken)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: words fetched but not yet consumed by decode,
  // the architectural next fetch address, and a pending drain.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } ent_t;
  ent_t        q[$];
  logic [31:0] mpc;
  logic [31:0] daddr;
  bit          drain;

`ifdef FETCH_JAL_PREDICT_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[21:2], 12'h013};
  endfunction

  function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] w);
    int imm;
    imm = 0;
    if (w[31]) imm = -(1 << 20);
    imm = imm + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
    return (pc + imm) & 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    chk("imem_read", {31'd0, imem_read}, {31'd0, q.size() < 2});
    if (q.size() < 2) chk("imem_address", imem_address, drain ? daddr : mpc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_instr", if_instr, q[0].instr);
      chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, q[0].pred});
    end else begin
      chk("if_instr_nop", if_instr, 32'h0000_0013);
      chk("if_pred_idle", {31'd0, if_pred_taken}, 32'd0);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check.
  task automatic cyc(input logic st, input logic rv, input logic [31:0] rp,
                     input logic rs, input logic jal = 1'b0);
    logic        s_read, s_valid, rs_eff, pj;
    logic [31:0] w;
    s_read  = imem_read;
    s_valid = if_valid;
    w       = jal ? 32'h0080_00EF : mem(imem_address);
    rs_eff  = rs & s_read;
    id_stall       = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_resp      = rs_eff;
    imem_rdata     = w;
    @(posedge clk);
    if (s_valid && !st) void'(q.pop_front());
    if (rv) begin
      q.delete();
      if (drain) begin
        if (rs_eff) drain = 1'b0;
      end else if (s_read && !rs_eff) begin
        drain = 1'b1;
        daddr = mpc;
      end
      mpc = rp & 32'hFFFF_FFFC;
    end else if (drain) begin
      if (rs_eff) drain = 1'b0;
    end else if (rs_eff) begin
      pj = JAL_EN && (w[6:0] == 7'b1101111);
      q.push_back('{pc: mpc, instr: w, pred: pj});
      mpc = pj ? jal_target(mpc, w) : mpc + 32'd4;
    end
    @(negedge clk);
    #1;
    check_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_resp = 1'b0; imem_rdata = '0;
    mpc = 32'h60; daddr = '0; drain = 1'b0;
    #22;
    chk("rst_imem_read", {31'd0, imem_read}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_if_pred", {31'd0, if_pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_cycle();
    chk("first_addr", imem_address, 32'h60);

    // Back-to-back fetch, memory answering in the request cycle.
    cyc(0, 0, 0, 1);
    chk("b2b_pc0", if_pc, 32'h60);
    chk("b2b_addr1", imem_address, 32'h64);
    cyc(0, 0, 0, 1);
    chk("b2b_pc1", if_pc, 32'h64);
    chk("b2b_addr2", imem_address, 32'h68);
    cyc(0, 0, 0, 1);
    chk("b2b_pc2", if_pc, 32'h68);

    // Stall: next response goes to the skid, request drops while holding.
    cyc(1, 0, 0, 1);
    chk("hold_read", {31'd0, imem_read}, 32'd0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("skid_pc", if_pc, 32'h6C);
    chk("skid_instr", if_instr, 32'h0000_1B013);

    // Redirect while 0x70 is outstanding; its late response is dropped.
    chk("pre_drain_addr", imem_address, 32'h70);
    cyc(0, 1, 32'h200, 0);
    chk("drain_addr", imem_address, 32'h70);
    chk("drain_valid", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("post_drain_addr", imem_address, 32'h200);
    chk("post_drain_valid", {31'd0, if_valid}, 32'd0);

    // Redirect coincident with a response; low target bits ignored.
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h103, 1);
    chk("coinc_valid", {31'd0, if_valid}, 32'd0);
    chk("coinc_addr", imem_address, 32'h100);

    // Address wrap at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 1);
    chk("wrap_pre", imem_address, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("wrap_addr", imem_address, 32'h0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);

    // jal x1,+8 fetched at 0x60.
    cyc(0, 1, 32'h60, 1);
    chk("jal_pre_addr", imem_address, 32'h60);
    cyc(0, 0, 0, 1, 1'b1);
    chk("jal_next_addr", imem_address, JAL_EN ? 32'h68 : 32'h64);
    chk("jal_pred", {31'd0, if_pred_taken}, {31'd0, JAL_EN});

    // Redirect in HOLD, then repeated redirects during a drain.
    cyc(1, 0, 0, 1);
    chk("hold2_read", {31'd0, imem_read}, 32'd0);
    cyc(1, 1, 32'h300, 0);
    chk("hold_redir_addr", imem_address, 32'h300);
    chk("hold_redir_valid", {31'd0, if_valid}, 32'd0);
    cyc(0, 1, 32'h400, 0);
    cyc(0, 1, 32'h500, 0);
    chk("drain2_addr", imem_address, 32'h300);
    cyc(0, 0, 0, 1);
    chk("drain2_done_addr", imem_address, 32'h500);

    // Mixed traffic checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom(),
          $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
